// File: rtl/red_pitaya_exp_in_pkg.sv
// red_pitaya_exp_in_pkg
//   Shared constants for the expansion-connector input conditioner:
//   register offsets (decoded on sys_addr[19:0]) and the default width of
//   the debounce length register / per-bit counters.
//   Optional feature macro: RED_PITAYA_EXP_IN_TIMESTAMP_EN (see top module).
package red_pitaya_exp_in_pkg;

  localparam int DEB_W_DEF = 20;  // ~8.4 ms max hold-off at 125 MHz

  localparam logic [19:0] ADDR_DEB   = 20'h00;  // RW debounce length
  localparam logic [19:0] ADDR_STATE = 20'h04;  // RO filtered pin state
  localparam logic [19:0] ADDR_RISE  = 20'h08;  // W1C rising-edge flags
  localparam logic [19:0] ADDR_FALL  = 20'h0C;  // W1C falling-edge flags
  localparam logic [19:0] ADDR_MASK  = 20'h10;  // RW interrupt mask
  localparam logic [19:0] ADDR_TS    = 20'h14;  // RO event timestamp

endpackage

// File: rtl/red_pitaya_exp_in_if.sv
// red_pitaya_exp_in_if
//   System-bus slot carrying the standard sys_* handshake.
//   master: drives address, write data, byte select and the strobes.
//   slave : returns read data, error and acknowledge.
interface red_pitaya_exp_in_if;
  logic [31:0] sys_addr;
  logic [31:0] sys_wdata;
  logic [3:0]  sys_sel;
  logic        sys_wen;
  logic        sys_ren;
  logic [31:0] sys_rdata;
  logic        sys_err;
  logic        sys_ack;

  modport master (
    output sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren,
    input  sys_rdata, sys_err, sys_ack
  );

  modport slave (
    input  sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren,
    output sys_rdata, sys_err, sys_ack
  );
endinterface

// File: rtl/red_pitaya_debounce.sv
// red_pitaya_debounce
//   One input bit: 2-FF synchroniser, hold-off counter and edge detect.
//   Ports:
//     clk_i, rst_i   clock, synchronous active-high reset
//     pin_i          raw asynchronous pin
//     len_i          debounce length N (a change must persist N+1 samples)
//     filt_o         filtered level
//     rise_pulse_o   one-cycle pulse after filt_o goes 0->1
//     fall_pulse_o   one-cycle pulse after filt_o goes 1->0
module red_pitaya_debounce #(
  parameter int DEB_W = 20
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pin_i,
  input  logic [DEB_W-1:0] len_i,
  output logic             filt_o,
  output logic             rise_pulse_o,
  output logic             fall_pulse_o
);

  logic             s1_reg;
  logic             s2_reg;
  logic             filt_reg;
  logic             filt_d_reg;
  logic [DEB_W-1:0] cnt_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_reg     <= 1'b0;
      s2_reg     <= 1'b0;
      filt_reg   <= 1'b0;
      filt_d_reg <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      s1_reg     <= pin_i;
      s2_reg     <= s1_reg;
      filt_d_reg <= filt_reg;
      if (s2_reg == filt_reg) begin
        // Any matching sample restarts the hold-off, rejecting glitches.
        cnt_reg <= '0;
      end else if (cnt_reg >= len_i) begin
        // >= rather than == so that shrinking len_i mid-count accepts the
        // change on the next mismatch instead of wrapping the counter.
        filt_reg <= s2_reg;
        cnt_reg  <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign filt_o       = filt_reg;
  assign rise_pulse_o = filt_reg & ~filt_d_reg;
  assign fall_pulse_o = ~filt_reg & filt_d_reg;

endmodule

// File: rtl/red_pitaya_exp_in.sv
// red_pitaya_exp_in
//   Conditions the 2*NB expansion-connector inputs (NB P-side, NB N-side)
//   before housekeeping consumes them: per-bit synchroniser + debounce,
//   sticky rise/fall flags (W1C), masked level interrupt, register slot.
//   Ports:
//     clk_i, rst_i               clock, synchronous active-high reset
//     exp_p_pin_i/exp_n_pin_i    raw asynchronous pins
//     exp_p_dat_o/exp_n_dat_o    filtered state
//     irq_o                      registered |((rise|fall) & mask)
//     sys                        system-bus slave slot
//   Registers (sys_addr[19:0]): 0x00 deb_len, 0x04 state {N,P}, 0x08 rise,
//   0x0C fall, 0x10 mask, 0x14 timestamp.
//   Optional: define RED_PITAYA_EXP_IN_TIMESTAMP_EN to add a free-running
//   32-bit cycle counter latched into 0x14 when the first masked flag sets;
//   otherwise 0x14 reads 0.
module red_pitaya_exp_in
  import red_pitaya_exp_in_pkg::*;
#(
  parameter int DEB_W = DEB_W_DEF,
  parameter int NB    = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [NB-1:0] exp_p_pin_i,
  input  logic [NB-1:0] exp_n_pin_i,
  output logic [NB-1:0] exp_p_dat_o,
  output logic [NB-1:0] exp_n_dat_o,
  output logic          irq_o,
  red_pitaya_exp_in_if.slave sys
);

  localparam int NF = 2 * NB;  // P bits in [NB-1:0], N bits above

  logic [NF-1:0]    pin_all;
  logic [NF-1:0]    filt_all;
  logic [NF-1:0]    rise_pulse;
  logic [NF-1:0]    fall_pulse;

  logic [DEB_W-1:0] deb_len_reg;
  logic [NF-1:0]    rise_reg, rise_next;
  logic [NF-1:0]    fall_reg, fall_next;
  logic [NF-1:0]    mask_reg;
  logic             irq_reg;
  logic             ack_reg;
  logic [31:0]      rdata_reg, rdata_next;
  logic [31:0]      ts_val;

  logic [19:0]      addr;
  logic             wr_rise, wr_fall;

  assign pin_all = {exp_n_pin_i, exp_p_pin_i};
  assign addr    = sys.sys_addr[19:0];

  genvar gi;
  generate
    for (gi = 0; gi < NF; gi++) begin : g_bit
      red_pitaya_debounce #(.DEB_W(DEB_W)) u_deb (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .pin_i        (pin_all[gi]),
        .len_i        (deb_len_reg),
        .filt_o       (filt_all[gi]),
        .rise_pulse_o (rise_pulse[gi]),
        .fall_pulse_o (fall_pulse[gi])
      );
    end
  endgenerate

  // Flag update: the W1C clear is applied first and the new event OR-ed in
  // afterwards, so an event arriving with a clear keeps the flag set.
  always_comb begin
    wr_rise   = sys.sys_wen && (addr == ADDR_RISE);
    wr_fall   = sys.sys_wen && (addr == ADDR_FALL);
    rise_next = rise_reg;
    fall_next = fall_reg;
    if (wr_rise) rise_next = rise_next & ~sys.sys_wdata[NF-1:0];
    if (wr_fall) fall_next = fall_next & ~sys.sys_wdata[NF-1:0];
    rise_next = rise_next | rise_pulse;
    fall_next = fall_next | fall_pulse;
  end

  always_comb begin
    rdata_next = '0;
    case (addr)
      ADDR_DEB:   rdata_next = 32'(deb_len_reg);
      ADDR_STATE: rdata_next = 32'(filt_all);
      ADDR_RISE:  rdata_next = 32'(rise_reg);
      ADDR_FALL:  rdata_next = 32'(fall_reg);
      ADDR_MASK:  rdata_next = 32'(mask_reg);
      ADDR_TS:    rdata_next = ts_val;
      default:    rdata_next = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      deb_len_reg <= '0;
      rise_reg    <= '0;
      fall_reg    <= '0;
      mask_reg    <= '0;
      irq_reg     <= 1'b0;
      ack_reg     <= 1'b0;
      rdata_reg   <= '0;
    end else begin
      rise_reg <= rise_next;
      fall_reg <= fall_next;
      irq_reg  <= |((rise_reg | fall_reg) & mask_reg);
      ack_reg  <= sys.sys_wen | sys.sys_ren;
      if (sys.sys_wen | sys.sys_ren) rdata_reg <= rdata_next;
      if (sys.sys_wen && (addr == ADDR_DEB))  deb_len_reg <= sys.sys_wdata[DEB_W-1:0];
      if (sys.sys_wen && (addr == ADDR_MASK)) mask_reg    <= sys.sys_wdata[NF-1:0];
    end
  end

`ifdef RED_PITAYA_EXP_IN_TIMESTAMP_EN
  logic [31:0] ts_cnt_reg;
  logic [31:0] ts_reg;
  logic        masked_now;
  logic        masked_next;

  assign masked_now  = |((rise_reg  | fall_reg)  & mask_reg);
  assign masked_next = |((rise_next | fall_next) & mask_reg);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ts_cnt_reg <= '0;
      ts_reg     <= '0;
    end else begin
      ts_cnt_reg <= ts_cnt_reg + 32'd1;
      // Capture only on the transition "no masked flag" -> "some masked
      // flag"; later events are ignored until software clears them all.
      if (!masked_now && masked_next) ts_reg <= ts_cnt_reg;
    end
  end

  assign ts_val = ts_reg;
`else
  assign ts_val = '0;
`endif

  assign exp_p_dat_o   = filt_all[NB-1:0];
  assign exp_n_dat_o   = filt_all[NF-1:NB];
  assign irq_o         = irq_reg;
  assign sys.sys_rdata = rdata_reg;
  assign sys.sys_ack   = ack_reg;
  assign sys.sys_err   = 1'b0;

  // Byte select and the high address/data bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{sys.sys_sel, sys.sys_addr[31:20], sys.sys_wdata[31:NF]};

endmodule

// File: tb/tb_red_pitaya_exp_in.sv
// Directed bench for red_pitaya_exp_in. "Edge 0" is the clock edge just
// before a pin is driven; inputs change 1 time unit after an edge and
// outputs are checked 1 time unit after the edge of interest.
module tb_red_pitaya_exp_in;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [7:0] exp_p_pin_i = '0;
  logic [7:0] exp_n_pin_i = '0;
  logic [7:0] exp_p_dat_o;
  logic [7:0] exp_n_dat_o;
  logic       irq_o;

  int total = 0;
  int bad   = 0;

  red_pitaya_exp_in_if bus ();

  red_pitaya_exp_in dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .exp_p_pin_i (exp_p_pin_i),
    .exp_n_pin_i (exp_n_pin_i),
    .exp_p_dat_o (exp_p_dat_o),
    .exp_n_dat_o (exp_n_dat_o),
    .irq_o       (irq_o),
    .sys         (bus)
  );

  always #5 clk_i = ~clk_i;

`ifdef RED_PITAYA_EXP_IN_TIMESTAMP_EN
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [19:0] a, input logic [31:0] d);
    bus.sys_addr  = {12'h0, a};
    bus.sys_wdata = d;
    bus.sys_wen   = 1'b1;
    step(1);
    bus.sys_wen   = 1'b0;
  endtask

  task automatic rd(input logic [19:0] a, output logic [31:0] d);
    bus.sys_addr = {12'h0, a};
    bus.sys_ren  = 1'b1;
    step(1);
    bus.sys_ren  = 1'b0;
    chk($sformatf("ack@%h", a), {31'h0, bus.sys_ack}, 32'h1);
    d = bus.sys_rdata;
  endtask

  task automatic rdchk(input string tag, input logic [19:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    chk(tag, d, exp);
  endtask

  initial begin
    logic [31:0] t1, t2;
`ifdef RED_PITAYA_EXP_IN_TIMESTAMP_EN
    int c1, c2;
`endif
    bus.sys_addr  = '0;
    bus.sys_wdata = '0;
    bus.sys_sel   = 4'hF;
    bus.sys_wen   = 1'b0;
    bus.sys_ren   = 1'b0;
    t1 = '0;
    t2 = '0;

    // Reset state
    step(3);
    rst_i = 1'b0;
    chk("rst_p_dat", {24'h0, exp_p_dat_o}, 32'h0);
    chk("rst_n_dat", {24'h0, exp_n_dat_o}, 32'h0);
    chk("rst_irq",   {31'h0, irq_o}, 32'h0);
    chk("rst_ack",   {31'h0, bus.sys_ack}, 32'h0);
    chk("rst_err",   {31'h0, bus.sys_err}, 32'h0);
    rdchk("rst_deb",   20'h00, 32'h0);
    rdchk("rst_state", 20'h04, 32'h0);
    rdchk("rst_rise",  20'h08, 32'h0);
    rdchk("rst_fall",  20'h0C, 32'h0);
    rdchk("rst_mask",  20'h10, 32'h0);
    rdchk("rst_ts",    20'h14, 32'h0);

    // deb_len=0: P0 visible at edge 3, rise flag at edge 4
    exp_p_pin_i[0] = 1'b1;
    step(2);
    chk("p0_edge2", {24'h0, exp_p_dat_o}, 32'h00);
    step(1);
    chk("p0_edge3", {24'h0, exp_p_dat_o}, 32'h01);
    rdchk("rise_edge4_old", 20'h08, 32'h0000);
    rdchk("rise_edge5",     20'h08, 32'h0001);
    rdchk("fall_none",      20'h0C, 32'h0000);
    chk("irq_unmasked0", {31'h0, irq_o}, 32'h0);
    wr(20'h08, 32'h1);
    rdchk("rise_cleared", 20'h08, 32'h0);
    rdchk("state_p0",     20'h04, 32'h0001);

    // deb_len=10: short pulse on N3 rejected
    wr(20'h00, 32'd10);
    rdchk("deb_rb", 20'h00, 32'd10);
    exp_n_pin_i[3] = 1'b1;
    step(5);
    exp_n_pin_i[3] = 1'b0;
    step(20);
    chk("glitch_n_dat", {24'h0, exp_n_dat_o}, 32'h00);
    rdchk("glitch_rise", 20'h08, 32'h0);
    rdchk("glitch_fall", 20'h0C, 32'h0);

    // 20-cycle pulse: high at edge 13, low 13 edges after release
    exp_n_pin_i[3] = 1'b1;
    step(12);
    chk("n3_edge12", {24'h0, exp_n_dat_o}, 32'h00);
    step(1);
    chk("n3_edge13", {24'h0, exp_n_dat_o}, 32'h08);
    step(7);
    exp_n_pin_i[3] = 1'b0;
    step(12);
    chk("n3_rel12", {24'h0, exp_n_dat_o}, 32'h08);
    step(1);
    chk("n3_rel13", {24'h0, exp_n_dat_o}, 32'h00);
    step(2);
    rdchk("n3_rise", 20'h08, 32'h0800);
    rdchk("n3_fall", 20'h0C, 32'h0800);
    wr(20'h08, 32'h0800);
    wr(20'h0C, 32'h0800);
    rdchk("n3_rise_clr", 20'h08, 32'h0);
    rdchk("n3_fall_clr", 20'h0C, 32'h0);

    // Interrupt on masked P0 events
    wr(20'h00, 32'd0);
    wr(20'h10, 32'h0001);
    exp_p_pin_i[0] = 1'b0;           // fall flag at edge 4, irq at edge 5
    step(4);
    chk("irq_edge4", {31'h0, irq_o}, 32'h0);
    step(1);
    chk("irq_edge5", {31'h0, irq_o}, 32'h1);
    wr(20'h0C, 32'h1);
    chk("irq_hold_clr", {31'h0, irq_o}, 32'h1);
    step(1);
    chk("irq_deassert", {31'h0, irq_o}, 32'h0);

    exp_p_pin_i[0] = 1'b1;           // rise flag at edge 4
    step(5);
    chk("irq_rise", {31'h0, irq_o}, 32'h1);
    exp_p_pin_i[0] = 1'b0;           // fall flag at edge 4
    step(4);
    wr(20'h0C, 32'h1);
    exp_p_pin_i[0] = 1'b1;           // new rise lands at edge 4
    step(3);
    wr(20'h08, 32'h1);               // clear hits the same edge
    rdchk("set_wins", 20'h08, 32'h0001);
    chk("irq_set_wins", {31'h0, irq_o}, 32'h1);
    rdchk("fall_after", 20'h0C, 32'h0);
    wr(20'h08, 32'h1);
    rdchk("rise_clr2", 20'h08, 32'h0);
    chk("irq_clr2", {31'h0, irq_o}, 32'h0);

    // Unmasked event keeps irq low; unmapped read
    exp_p_pin_i[1] = 1'b1;
    step(8);
    chk("irq_unmasked", {31'h0, irq_o}, 32'h0);
    rdchk("p1_rise", 20'h08, 32'h0002);
    wr(20'h08, 32'h2);
    rdchk("unmapped", 20'h40, 32'h0);
    step(1);
    chk("ack_drop", {31'h0, bus.sys_ack}, 32'h0);

`ifdef RED_PITAYA_EXP_IN_TIMESTAMP_EN
    wr(20'h10, 32'h0002);
    exp_p_pin_i[1] = 1'b0;
    c1 = cyc;
    step(6);
    rd(20'h14, t1);
    exp_p_pin_i[1] = 1'b1;          // second masked event must not re-latch
    step(6);
    rdchk("ts_hold", 20'h14, t1);
    wr(20'h0C, 32'h2);
    wr(20'h08, 32'h2);
    exp_p_pin_i[1] = 1'b0;
    c2 = cyc;
    step(6);
    rd(20'h14, t2);
    chk("ts_delta", t2 - t1, 32'(c2 - c1));
`else
    rdchk("ts_absent", 20'h14, 32'h0);
`endif

    // Reset mid-operation drops the pending ack
    wr(20'h10, 32'h0001);
    bus.sys_addr = 32'h0;
    bus.sys_ren  = 1'b1;
    step(1);
    bus.sys_ren  = 1'b0;
    rst_i        = 1'b1;
    step(1);
    chk("midrst_ack",   {31'h0, bus.sys_ack}, 32'h0);
    chk("midrst_p_dat", {24'h0, exp_p_dat_o}, 32'h0);
    chk("midrst_irq",   {31'h0, irq_o}, 32'h0);
    rst_i = 1'b0;
    rdchk("midrst_mask", 20'h10, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
